// File: rtl/fetch_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_pkg                                                          |
// | Shared defaults, the fetch FIFO entry type and the PC increment.   |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
package fetch_pkg;

  localparam int FETCH_ADDR_W   = 8;
  localparam int FETCH_DATA_W   = 32;
  localparam int FETCH_RESET_PC = 0;
  localparam int PC_STEP        = 4;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_DATA_W-1:0] instr;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_fifo                                                         |
// | Strict-order synchronous FIFO with push/pop/flush and head output. |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = fetch_entry_t,
  parameter int  CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  entry_t           push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output entry_t           head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  entry_t           r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Flush dominates; a same-cycle pop of an empty FIFO is ignored.
  assign w_do_push = push & ~flush;
  assign w_do_pop  = pop & ~flush & (r_count != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_data;
  end

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;
  assign empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | instr_fetch                                                        |
// | PC, ROM request issue, redirect/flush and {pc,instr} output FIFO.  |
// | Optional FETCH_MISALIGN_EN: halt on misaligned redirect targets.   |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int                ADDR_W     = FETCH_ADDR_W,
  parameter int                DATA_W     = FETCH_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(FETCH_RESET_PC),
  parameter int                FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_dout,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic              misalign
);

  localparam int                CNT_W     = $clog2(FIFO_DEPTH + 1);
  localparam int                OCC_W     = CNT_W + 1;
  localparam logic [ADDR_W-1:0] C_PC_STEP = ADDR_W'(PC_STEP);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } entry_t;

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_inflight_pc;
  logic              r_inflight;
  logic              r_misalign;

  logic [CNT_W-1:0]  w_count;
  logic [OCC_W-1:0]  w_occ_after;
  logic              w_empty;
  logic              w_pop;
  logic              w_push;
  logic              w_issue;
  logic [ADDR_W-1:0] w_redirect_pc;
  logic              w_redirect_misalign;
  entry_t            w_push_data;
  entry_t            w_head;

`ifdef FETCH_MISALIGN_EN
  assign w_redirect_pc       = redirect_pc;
  assign w_redirect_misalign = |redirect_pc[1:0];
`else
  logic w_unused_pc_lsb;
  assign w_redirect_pc       = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign w_redirect_misalign = 1'b0;
  assign w_unused_pc_lsb     = ^redirect_pc[1:0];
`endif

  assign out_valid = ~w_empty;
  assign w_pop     = out_valid & out_ready;

  // Occupancy after this edge's pop, counting the read still in flight,
  // so an issued request always has a FIFO slot when its data returns.
  assign w_occ_after = OCC_W'(w_count) + OCC_W'(r_inflight) - OCC_W'(w_pop);
  assign w_issue     = ~rst & ~redirect_valid & ~r_misalign &
                       (w_occ_after < OCC_W'(FIFO_DEPTH));

  // A redirect discards the response of the read issued last cycle.
  assign w_push      = r_inflight & ~redirect_valid;
  assign w_push_data = '{pc: r_inflight_pc, instr: rom_dout};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_misalign    <= 1'b0;
    end else if (redirect_valid) begin
      r_pc          <= w_redirect_pc;
      r_inflight    <= 1'b0;
      r_misalign    <= w_redirect_misalign;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_pc <= r_pc;
        r_pc          <= r_pc + C_PC_STEP;
      end
    end
  end

  fetch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t),
    .CNT_W   (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (w_pop),
    .flush     (redirect_valid),
    .count     (w_count),
    .empty     (w_empty),
    .head      (w_head)
  );

  // Head storage is not reset, so present zeros whenever the FIFO is empty.
  assign out_pc    = w_empty ? '0 : w_head.pc;
  assign out_instr = w_empty ? '0 : w_head.instr;
  assign rom_addr  = r_pc;
  assign misalign  = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_instr_fetch                                                     |
// | Directed bench with 1-cycle ROM model and an output scoreboard.    |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rom_addr;
  logic [31:0] rom_dout;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [7:0]  out_pc;
  logic        misalign;

  int n_pass  = 0;
  int n_total = 0;
  logic [39:0] q[$];

  always #5 clk = ~clk;

  instr_fetch #(
    .ADDR_W     (8),
    .DATA_W     (32),
    .RESET_PC   (8'h00),
    .FIFO_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rom_addr       (rom_addr),
    .rom_dout       (rom_dout),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .misalign       (misalign)
  );

  // ROM: word k holds 0x1000_0000 + k, one cycle of read latency.
  always @(posedge clk) rom_dout <= 32'h1000_0000 + 32'(rom_addr >> 2);

  function automatic logic [39:0] entry(input logic [7:0] pc);
    return {pc, 32'h1000_0000 + 32'(pc >> 2)};
  endfunction

  task automatic expect_seq(input logic [7:0] start, input int n);
    logic [7:0] p;
    p = start;
    for (int i = 0; i < n; i++) begin
      q.push_back(entry(p));
      p = p + 8'd4;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  // Compare any transfer completing at the coming edge, then advance.
  task automatic tick();
    logic [39:0] exp;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      n_total++;
      if (q.size() == 0) begin
        $error("FAIL sb_extra: observed %0h, expected none", {out_pc, out_instr});
      end else begin
        exp = q.pop_front();
        assert ({out_pc, out_instr} === exp) n_pass++;
        else $error("FAIL sb_order: observed %0h, expected %0h", {out_pc, out_instr}, exp);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [7:0] target, input logic [7:0] first_pc);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    tick();
    redirect_valid = 1'b0;
    q.delete();
    expect_seq(first_pc, 40);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_addr",   64'(rom_addr),  64'h0);
    check("rst_valid",  64'(out_valid), 64'h0);
    check("rst_instr",  64'(out_instr), 64'h0);
    check("rst_pc",     64'(out_pc),    64'h0);
    check("rst_misal",  64'(misalign),  64'h0);

    // Startup with decode ready
    rst       = 1'b0;
    out_ready = 1'b1;
    expect_seq(8'h00, 40);
    tick();
    check("e0_addr",  64'(rom_addr),  64'h04);
    check("e0_valid", 64'(out_valid), 64'h0);
    tick();
    check("e1_addr",  64'(rom_addr),  64'h08);
    check("e1_valid", 64'(out_valid), 64'h1);
    check("e1_head",  {out_pc, out_instr}, 64'(entry(8'h00)));
    tick();

    // Backpressure
    out_ready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_head", {out_pc, out_instr}, 64'h04_1000_0001);
      check("bp_addr", 64'(rom_addr), 64'h0C);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("drain_valid", 64'(out_valid), 64'h1);
    end
    check("pre_redir_addr", 64'(rom_addr), 64'h14);

    // Redirect while the 0x10 read is in flight
    redirect(8'h40, 8'h40);
    check("r_addr",  64'(rom_addr),  64'h40);
    check("r_valid", 64'(out_valid), 64'h0);
    tick();
    check("r1_valid", 64'(out_valid), 64'h0);
    tick();
    check("r2_valid", 64'(out_valid), 64'h1);
    check("r2_head",  {out_pc, out_instr}, 64'h40_1000_0010);
    repeat (2) tick();

    // PC wrap
    redirect(8'hF8, 8'hF8);
    repeat (2) tick();
    check("wrap_head", {out_pc, out_instr}, 64'hF8_1000_003E);
    repeat (3) tick();
    check("wrap_q", 64'(q[0]), 64'(entry(8'h04)));

`ifdef FETCH_MISALIGN_EN
    redirect(8'h22, 8'h22);
    q.delete();
    check("mis_set", 64'(misalign), 64'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mis_valid", 64'(out_valid), 64'h0);
      check("mis_addr",  64'(rom_addr),  64'h22);
    end
    redirect(8'h24, 8'h24);
    check("mis_clr", 64'(misalign), 64'h0);
    repeat (2) tick();
    check("mis_head", {out_pc, out_instr}, 64'h24_1000_0009);
`else
    redirect(8'h22, 8'h20);
    check("align_addr",  64'(rom_addr), 64'h20);
    check("align_misal", 64'(misalign), 64'h0);
    repeat (2) tick();
    check("align_head", {out_pc, out_instr}, 64'h20_1000_0008);
`endif
    repeat (2) tick();

    // Asynchronous reset with entries buffered
    out_ready = 1'b0;
    repeat (3) tick();
    check("pre_rst_valid", 64'(out_valid), 64'h1);
    rst = 1'b1;
    #1;
    check("arst_valid", 64'(out_valid), 64'h0);
    check("arst_addr",  64'(rom_addr),  64'h00);
    check("arst_pc",    64'(out_pc),    64'h00);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    q.delete();
    expect_seq(8'h00, 40);
    tick();
    check("re0_valid", 64'(out_valid), 64'h0);
    tick();
    check("re1_head", {out_pc, out_instr}, 64'h00_1000_0000);
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit: the initiator for the synchronous instruction ROM read port. It holds the program counter, drives word-aligned byte addresses into the ROM, captures the returned words, and hands `{pc, instr}` pairs to decode through a small valid/ready FIFO. It supports branch/jump redirects with flush and discards any in-flight read.

## Interface
- `ADDR_W`, default 8: ROM byte-address width; also the PC width.
- `DATA_W`, default 32: instruction width.
- `RESET_PC`, default 0: PC loaded on reset. Must be word-aligned.
- `FIFO_DEPTH`, default 2: output buffer entries. Minimum 2.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `rom_addr` out ADDR_W: byte address to the ROM; equals the current PC register.
- `rom_dout` in DATA_W: ROM read data, valid one cycle after the ROM samples `rom_addr`.
- `redirect_valid` in 1: load a new PC this cycle.
- `redirect_pc` in ADDR_W: redirect target byte address.
- `out_valid` out 1: FIFO head is valid.
- `out_ready` in 1: decode accepts the head.
- `out_instr` out DATA_W: instruction at the FIFO head.
- `out_pc` out ADDR_W: byte address of `out_instr`.
- `misalign` out 1: sticky misaligned-redirect flag. Tied to 0 without the macro.

## Operation
- State: `pc`, `inflight` (1 bit), `inflight_pc`, FIFO `count`, and the `misalign` flag.
- `pop = out_valid & out_ready`.
- `issue = !rst & !redirect_valid & !halted & (count + inflight - pop < FIFO_DEPTH)`.
  - `halted` is the `misalign` flag.
- On issue:
  - The ROM samples `rom_addr` at this edge.
  - `inflight <= 1`, `inflight_pc <= pc`, `pc <= pc + 4`.
- No issue: `inflight <= 0`, `pc` holds.
- Push: at every edge where `inflight == 1` and there is no redirect, `{inflight_pc, rom_dout}` is written to the FIFO.
  - The issue rule guarantees space; push and pop may occur in the same cycle.
- PC arithmetic is mod 2^ADDR_W: `pc = 0xFC` with issue gives `0x00`. No carry, no flag.
- Redirect has priority over everything:
  - FIFO flushed (`count <= 0`), `inflight <= 0` (the response is discarded), `pc <= redirect_pc`, no issue.
  - A `pop` in the same cycle is a completed transfer from decode's view; no entry survives.
- The FIFO is strict order; the head is stable while `out_valid & !out_ready`.

## Timing
- Reset values:
  - `pc = rom_addr = RESET_PC`.
  - `out_valid = 0`, `out_instr = 0`, `out_pc = 0`.
  - `inflight = 0`, `count = 0`, `misalign = 0`.
- Reset mid-operation clears everything asynchronously. No ROM response is pushed after reset.
- Startup: `rst` falls before edge E0. E0 issues `RESET_PC`; E1 pushes it, so `out_valid = 1` after E1.
- Latency from issue edge to `out_valid`: 1 cycle if the FIFO is empty.
- Throughput: 1 instruction/cycle with `out_ready` held high.
- Backpressure:
  - With `out_ready` low, fetch stops once `count + inflight == FIFO_DEPTH`.
  - After `out_ready` rises it resumes on the same edge as the pop.
- Redirect at edge R: `rom_addr = redirect_pc` after R. Issue at R+1; first `out_valid` after R+2.

## Configuration
- `FETCH_MISALIGN_EN` defined:
  - A redirect with `redirect_pc[1:0] != 0` flushes as normal, loads `pc`, sets `misalign` and halts issue.
  - The next aligned redirect clears `misalign` and resumes fetch.
- Not defined: `redirect_pc[1:0]` is forced to 0 and `misalign` is constant 0.

## Structure
- `fetch_pkg` holds:
  - `ADDR_W`, `DATA_W`, `RESET_PC` defaults.
  - `fetch_entry_t` struct `{pc, instr}`.
  - The `PC_STEP = 4` constant.
- Sub-module `fetch_fifo`: synchronous FIFO of `fetch_entry_t`, depth `FIFO_DEPTH`, with push/pop/flush, `count`, `empty` and head output. `instr_fetch` instantiates it.

## Test plan
The bench ROM model has 1-cycle latency and word k = `0x1000_0000 + k`.
- Reset then `out_ready = 1`:
  - `rom_addr` reads 0, 4, 8 on successive cycles.
  - `out_valid` rises after the second edge with `out_pc = 0x00`, `out_instr = 0x10000000`, then `0x04 / 0x10000001` every cycle.
- Backpressure: hold `out_ready = 0` from cycle 3.
  - `count` reaches 2, issue stops, and the head stays `0x04 / 0x10000001`.
  - On release, entries drain in order with no gap or duplicate.
- Redirect to `0x40` while an in-flight read of `0x10` exists:
  - The `0x10` word never appears.
  - Next `out_pc = 0x40`, `out_instr = 0x10000010`, two cycles after the redirect.
- Wrap: redirect to `0xF8`. Outputs are `0xF8`, `0xFC`, `0x00`, with `out_instr` `0x1000003E`, `0x1000003F`, `0x10000000`.
- Misalign with `FETCH_MISALIGN_EN`: redirect to `0x22`.
  - `misalign = 1`, `out_valid` stays 0.
  - Redirect to `0x24` clears it and yields `0x24 / 0x10000009`.
  - Without the macro, a redirect to `0x22` fetches `0x20 / 0x10000008`.
- Assert `rst` for one cycle mid-stream with 2 entries buffered: `out_valid` drops immediately and the sequence restarts at `RESET_PC`.
